// File: rtl/servo_pkg.sv
// Shared types and the angle-to-pulse-width conversion for the servo PWM generator.
package servo_pkg;

    localparam int unsigned ANGLE_MAX = 180;
    localparam int unsigned ANGLE_W   = 8;
    localparam int unsigned US_W      = 16;
    localparam int unsigned PROD_W    = 11;

    typedef logic [ANGLE_W-1:0] angle_t;
    typedef logic [US_W-1:0]    us_t;

    // 11 us per 2 deg; angles are pre-clamped to 180, so the 11-bit product never overflows
    function automatic us_t angle_to_us(angle_t a, us_t min_us);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(a) * PROD_W'(11);
        return min_us + us_t'(prod >> 1);
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo output: clamps the target angle, slews the applied angle at frame wrap,
// and compares the shared frame counter against the resulting pulse width.
module servo_channel
    import servo_pkg::*;
#(
    parameter int unsigned MIN_US     = 1000,
    parameter int unsigned MAX_STEP   = 2,
    parameter int unsigned HOME_ANGLE = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        frame_wrap,
    input  logic [15:0] frame_cnt,
    input  logic [7:0]  tgt,
    output logic        pwm
);

    localparam angle_t HOME      = angle_t'(HOME_ANGLE);
    localparam angle_t STEP      = angle_t'(MAX_STEP);
    localparam angle_t LIMIT     = angle_t'(ANGLE_MAX);
    localparam us_t    MIN_W     = us_t'(MIN_US);
    localparam bit     UNLIMITED = (MAX_STEP == 0);

    angle_t tgt_c;
    angle_t applied_q, applied_d;
    us_t    width_c;
    logic   pwm_q, pwm_d;

    // Applied angle moves toward the clamped target only at frame wrap, bounded by STEP
    always_comb begin
        tgt_c     = (tgt > LIMIT) ? LIMIT : tgt;
        applied_d = applied_q;
        if (frame_wrap && enable) begin
            if (tgt_c >= applied_q) begin
                if (UNLIMITED || ((tgt_c - applied_q) <= STEP)) begin
                    applied_d = tgt_c;
                end else begin
                    applied_d = applied_q + STEP;
                end
            end else begin
                if (UNLIMITED || ((applied_q - tgt_c) <= STEP)) begin
                    applied_d = tgt_c;
                end else begin
                    applied_d = applied_q - STEP;
                end
            end
        end
    end

    always_comb begin
        width_c = angle_to_us(applied_q, MIN_W);
        pwm_d   = enable && (frame_cnt < width_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            applied_q <= HOME;
            pwm_q     <= 1'b0;
        end else begin
            applied_q <= applied_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/servo_pwm_gen.sv
// Four-channel servo PWM generator: shared microsecond prescaler and frame counter,
// one servo_channel per output.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned FRAME_US   = 20000,
    parameter int unsigned MIN_US     = 1000,
    parameter int unsigned MAX_STEP   = 2,
    parameter int unsigned HOME_ANGLE = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] angle1,
    input  logic [7:0] angle2,
    input  logic [7:0] angle3,
    input  logic [7:0] angle4,
    output logic       pwm1,
    output logic       pwm2,
    output logic       pwm3,
    output logic       pwm4,
    output logic       frame_start
);

    localparam int unsigned DIV   = CLK_HZ / 1_000_000;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(DIV - 1);
    localparam us_t              FRAME_MAX = us_t'(FRAME_US - 1);

    logic [PRE_W-1:0] us_cnt_q, us_cnt_d;
    us_t              frame_cnt_q, frame_cnt_d;
    logic             frame_start_q;
    logic             us_tick_c;
    logic             frame_wrap_c;
    logic [7:0]       tgt_c [4];
    logic [3:0]       pwm_c;

    always_comb begin
        us_tick_c    = (us_cnt_q == PRE_MAX);
        frame_wrap_c = us_tick_c && (frame_cnt_q == FRAME_MAX);
        us_cnt_d     = us_tick_c ? '0 : us_cnt_q + 1'b1;
        frame_cnt_d  = frame_cnt_q;
        if (us_tick_c) begin
            frame_cnt_d = frame_wrap_c ? '0 : frame_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            us_cnt_q      <= '0;
            frame_cnt_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            us_cnt_q      <= us_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_wrap_c;
        end
    end

    assign tgt_c[0] = angle1;
    assign tgt_c[1] = angle2;
    assign tgt_c[2] = angle3;
    assign tgt_c[3] = angle4;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        servo_channel #(
            .MIN_US     (MIN_US),
            .MAX_STEP   (MAX_STEP),
            .HOME_ANGLE (HOME_ANGLE)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .enable     (enable),
            .frame_wrap (frame_wrap_c),
            .frame_cnt  (frame_cnt_q),
            .tgt        (tgt_c[i]),
            .pwm        (pwm_c[i])
        );
    end

    assign pwm1        = pwm_c[0];
    assign pwm2        = pwm_c[1];
    assign pwm3        = pwm_c[2];
    assign pwm4        = pwm_c[3];
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Scoreboard bench: two servo_pwm_gen instances (1 clk/us slew-limited, 2 clk/us unlimited)
// share stimulus; a frame-level model predicts per-frame pulse length and onset per channel.
module tb_servo_pwm_gen;

    localparam int FRAME_US = 2100;
    localparam int HOME     = 10;

    typedef struct packed {
        int hi;
        int first;
    } frame_exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] ang [4];
    logic [3:0] pwm_a, pwm_b;
    logic       fs_a, fs_b;

    int checks   = 0;
    int failures = 0;
    int t        = 0;

    frame_exp_t exp_q [8][$];
    bit         rst_edge = 1'b0;

    always #5 clk = ~clk;

    servo_pwm_gen #(
        .CLK_HZ(1_000_000), .FRAME_US(FRAME_US), .MIN_US(1000), .MAX_STEP(4), .HOME_ANGLE(HOME)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable),
        .angle1(ang[0]), .angle2(ang[1]), .angle3(ang[2]), .angle4(ang[3]),
        .pwm1(pwm_a[0]), .pwm2(pwm_a[1]), .pwm3(pwm_a[2]), .pwm4(pwm_a[3]),
        .frame_start(fs_a)
    );

    servo_pwm_gen #(
        .CLK_HZ(2_000_000), .FRAME_US(FRAME_US), .MIN_US(1000), .MAX_STEP(0), .HOME_ANGLE(HOME)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable),
        .angle1(ang[0]), .angle2(ang[1]), .angle3(ang[2]), .angle4(ang[3]),
        .pwm1(pwm_b[0]), .pwm2(pwm_b[1]), .pwm3(pwm_b[2]), .pwm4(pwm_b[3]),
        .frame_start(fs_b)
    );

    function automatic int div_of(int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int step_of(int d);
        return (d == 0) ? 4 : 0;
    endfunction

    function automatic int width_us(int a);
        return 1000 + (a * 11) / 2;
    endfunction

    function automatic int slew(int cur, int raw, int ms);
        int tg;
        int dl;
        tg = (raw > 180) ? 180 : raw;
        dl = tg - cur;
        if (ms == 0 || (dl <= ms && dl >= -ms)) return tg;
        return (dl > 0) ? cur + ms : cur - ms;
    endfunction

    task automatic expect_eq(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step(int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
            t += n;
        end
    endtask

    // Reference model: position within frame in clocks, applied angle per channel
    initial begin : model
        int pos [2];
        int applied [8];
        int acc [8];
        int first [8];
        int k;
        forever begin
            @(posedge clk);
            rst_edge = rst;
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    pos[d] = 0;
                    for (int c = 0; c < 4; c++) begin
                        k = d * 4 + c;
                        applied[k] = HOME;
                        acc[k]     = 0;
                        first[k]   = 0;
                        exp_q[k].delete();
                    end
                end else begin
                    for (int c = 0; c < 4; c++) begin
                        k = d * 4 + c;
                        if (enable && (pos[d] / div_of(d) < width_us(applied[k]))) begin
                            acc[k]++;
                            if (first[k] == 0) first[k] = pos[d] + 1;
                        end
                    end
                    pos[d]++;
                    if (pos[d] == div_of(d) * FRAME_US) begin
                        for (int c = 0; c < 4; c++) begin
                            k = d * 4 + c;
                            exp_q[k].push_back('{hi: acc[k], first: first[k]});
                            acc[k]   = 0;
                            first[k] = 0;
                            if (enable) applied[k] = slew(applied[k], int'(ang[c]), step_of(d));
                        end
                        pos[d] = 0;
                    end
                end
            end
        end
    end

    // Monitor: measures each frame between frame_start pulses and pops the expectation
    initial begin : monitor
        int idx [2];
        int mcnt [8];
        int mfirst [8];
        int k;
        int per;
        logic [3:0] pw;
        logic fsv;
        frame_exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                pw  = (d == 0) ? pwm_a : pwm_b;
                fsv = (d == 0) ? fs_a : fs_b;
                per = div_of(d) * FRAME_US;
                if (rst_edge) begin
                    idx[d] = 0;
                    for (int c = 0; c < 4; c++) begin
                        mcnt[d*4+c]   = 0;
                        mfirst[d*4+c] = 0;
                    end
                end else begin
                    idx[d]++;
                    for (int c = 0; c < 4; c++) begin
                        k = d * 4 + c;
                        if (pw[c]) begin
                            mcnt[k]++;
                            if (mfirst[k] == 0) mfirst[k] = idx[d];
                        end
                    end
                    if (fsv) begin
                        expect_eq($sformatf("frame_period dut%0d", d), idx[d], per);
                        for (int c = 0; c < 4; c++) begin
                            k = d * 4 + c;
                            if (exp_q[k].size() == 0) begin
                                checks++;
                                failures++;
                                $display("FAIL frame_expect dut%0d ch%0d: frame_start with no expected frame", d, c + 1);
                            end else begin
                                e = exp_q[k].pop_front();
                                expect_eq($sformatf("pulse_len dut%0d ch%0d", d, c + 1), mcnt[k], e.hi);
                                expect_eq($sformatf("pulse_onset dut%0d ch%0d", d, c + 1), mfirst[k], e.first);
                            end
                            mcnt[k]   = 0;
                            mfirst[k] = 0;
                        end
                        idx[d] = 0;
                    end else if (idx[d] > per + 4) begin
                        checks++;
                        failures++;
                        $display("FAIL frame_timeout dut%0d: no frame_start after %0d clk, want %0d", d, idx[d], per);
                        idx[d] = 0;
                    end
                end
            end
        end
    end

    initial begin : stim
        rst    = 1'b1;
        enable = 1'b1;
        for (int c = 0; c < 4; c++) ang[c] = 8'd10;
        step(3);
        expect_eq("reset pwm dut0", int'(pwm_a), 0);
        expect_eq("reset pwm dut1", int'(pwm_b), 0);
        expect_eq("reset frame_start dut0", int'(fs_a), 0);
        expect_eq("reset frame_start dut1", int'(fs_b), 0);
        rst = 1'b0;
        t   = 0;

        // Directed: clamp, slew, mid-frame change
        step(1000);
        ang[0] = 8'd180;
        ang[1] = 8'd30;
        step(1600);
        ang[2] = 8'd90;
        step(3800);
        ang[0] = 8'd200;
        step(2100);
        ang[0] = 8'd0;
        step(4200);
        ang[3] = 8'd255;
        step(4200);

        // Randomized targets and enable
        for (int i = 0; i < 10; i++) begin
            step(int'($urandom_range(200, 2500)));
            for (int c = 0; c < 4; c++) ang[c] = 8'($urandom_range(0, 255));
            enable = ($urandom_range(0, 9) != 0);
        end

        // Enable drop inside a pulse, held across a wrap
        enable = 1'b1;
        step(2100 - (t % 2100) + 300);
        enable = 1'b0;
        for (int c = 0; c < 4; c++) ang[c] = 8'd120;
        step(1);
        expect_eq("enable_off pwm dut0", int'(pwm_a), 0);
        expect_eq("enable_off pwm dut1", int'(pwm_b), 0);
        step(2500);
        enable = 1'b1;
        for (int c = 0; c < 4; c++) ang[c] = 8'd90;
        step(4200);

        // Reset in the middle of a pulse
        step(2100 - (t % 2100) + 900);
        rst = 1'b1;
        step(1);
        expect_eq("mid_reset pwm dut0", int'(pwm_a), 0);
        expect_eq("mid_reset pwm dut1", int'(pwm_b), 0);
        step(1);
        rst = 1'b0;
        t   = 0;
        step(2 * 4200 + 20);

        for (int k = 0; k < 8; k++) begin
            checks++;
            if (exp_q[k].size() > 1) begin
                failures++;
                $display("FAIL backlog q%0d: %0d frames unmatched, want at most 1", k, exp_q[k].size());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
